// File: rtl/ycbcr_pkg.sv
// Shared definitions for the YCbCr pixel buffer: channel indices, default sizes,
// the packed pixel layout and the output-stage state type.
package ycbcr_pkg;

    localparam int unsigned CH_Y  = 0;
    localparam int unsigned CH_CB = 1;
    localparam int unsigned CH_CR = 2;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_NUM_CH = 3;

    // Field order puts Y in the least significant bits of the packed word.
    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] cr;
        logic [DEFAULT_DATA_W-1:0] cb;
        logic [DEFAULT_DATA_W-1:0] y;
    } pixel_t;

    typedef enum logic {
        OutEmpty,
        OutFull
    } out_state_e;

    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned data_w);
        return ch * data_w;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// Read data holds its value when re is low, so the caller can park a word in it.
module sdp_ram #(
    parameter int unsigned WIDTH  = 96,
    parameter int unsigned DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ycbcr_pixel_fifo.sv
// Multi-channel pixel FIFO with a show-ahead output register fed from a registered RAM read.
// Level counts every stored pixel: those still in RAM, the one in the RAM read register, and rd_data.
module ycbcr_pixel_fifo
    import ycbcr_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned NUM_CH   = DEFAULT_NUM_CH,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned AFULL_TH = DEPTH - 4,
    localparam int unsigned ADDR_W  = $clog2(DEPTH),
    localparam int unsigned PIX_W   = NUM_CH * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [PIX_W-1:0]  rd_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              afull
);

    localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_AFULL = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LVL_ZERO  = '0;
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic              flush;
    logic              wr_fire;
    logic              pop;
    logic              land;
    logic              issue;
    logic [ADDR_W:0]   mem_cnt;
    logic [ADDR_W:0]   level_q, level_d;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic              rd_pend_q, rd_pend_d;
    logic [PIX_W-1:0]  ram_rdata;
    out_state_e        state_q, state_d;

    assign flush    = rst | clear;
    assign wr_ready = ~full;
    assign rd_valid = (state_q == OutFull);
    assign level    = level_q;
    assign wr_fire  = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    // Pixels written to RAM but not yet read out of it.
    assign mem_cnt = level_q - {{ADDR_W{1'b0}}, rd_valid} - {{ADDR_W{1'b0}}, rd_pend_q};

    // The RAM read register moves into rd_data when the output slot is free or being popped.
    assign land  = rd_pend_q & (~rd_valid | pop);
    // A new read may only overwrite the RAM read register once its word has moved on.
    assign issue = (mem_cnt != LVL_ZERO) & (~rd_pend_q | land);

    assign rd_pend_d = issue | (rd_pend_q & ~land);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OutEmpty: if (land)         state_d = OutFull;
            OutFull:  if (pop && !land) state_d = OutEmpty;
            default:                    state_d = OutEmpty;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (wr_fire && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (!wr_fire && pop) begin
            level_d = level_q - LVL_ONE;
        end
    end

    sdp_ram #(
        .WIDTH (PIX_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (issue),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_pend_q <= 1'b0;
            state_q   <= OutEmpty;
            rd_data   <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            afull     <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (land) begin
                rd_data <= ram_rdata;
            end
            level_q   <= level_d;
            rd_pend_q <= rd_pend_d;
            state_q   <= state_d;
            full      <= (level_d == LVL_FULL);
            empty     <= (level_d == LVL_ZERO);
            afull     <= (level_d >= LVL_AFULL);
        end
    end

endmodule

// File: tb/tb_ycbcr_pixel_fifo.sv
// Scoreboard bench for ycbcr_pixel_fifo: accepted writes are queued with their acceptance cycle;
// a negedge monitor checks level/flags, show-ahead latency, hold stability and data order.
module tb_ycbcr_pixel_fifo;

    localparam int unsigned DW  = 8;
    localparam int unsigned NC  = 3;
    localparam int unsigned DEP = 4;
    localparam int unsigned ATH = 3;
    localparam int unsigned PW  = DW * NC;

    logic          clk = 1'b0;
    logic          rst, clear, wr_valid, rd_ready;
    logic [PW-1:0] wr_data, rd_data;
    logic          wr_ready, rd_valid, full, empty, afull;
    logic [2:0]    level;

    always #5 clk = ~clk;

    ycbcr_pixel_fifo #(
        .DATA_W   (DW),
        .NUM_CH   (NC),
        .DEPTH    (DEP),
        .AFULL_TH (ATH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .afull    (afull)
    );

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    bit            chk_en = 1'b0;
    logic [PW-1:0] exp_data[$];
    int            exp_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stimulus side: record every pixel the buffer accepts, with the edge it was accepted on.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst || clear) begin
            exp_data.delete();
            exp_cyc.delete();
        end else if (wr_valid && wr_ready) begin
            exp_data.push_back(wr_data);
            exp_cyc.push_back(cyc);
        end
    end

    // Monitor: a stored pixel becomes visible two edges after acceptance once it is at the head.
    bit            hold_prev = 1'b0;
    logic [PW-1:0] prev_data;
    int            sz;
    bit            exp_v;

    always @(negedge clk) begin
        if (chk_en) begin
            sz = exp_data.size();
            chk("level", 64'(level), 64'(sz));
            chk("full", 64'(full), 64'(sz == DEP));
            chk("empty", 64'(empty), 64'(sz == 0));
            chk("afull", 64'(afull), 64'(sz >= ATH));
            chk("wr_ready", 64'(wr_ready), 64'(sz != DEP));
            exp_v = (sz > 0) ? (cyc >= exp_cyc[0] + 2) : 1'b0;
            chk("rd_valid", 64'(rd_valid), 64'(exp_v));
            if (hold_prev) begin
                chk("hold_valid", 64'(rd_valid), 64'(1));
                chk("hold_data", 64'(rd_data), 64'(prev_data));
            end
            if (rd_valid && rd_ready) begin
                if (sz > 0) begin
                    chk("rd_data", 64'(rd_data), 64'(exp_data[0]));
                    void'(exp_data.pop_front());
                    void'(exp_cyc.pop_front());
                end else begin
                    chk("pop_with_nothing_stored", 64'(1), 64'(0));
                end
            end
            hold_prev = rd_valid && !rd_ready && !rst && !clear;
            prev_data = rd_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [PW-1:0] fill_v [4];

    initial begin
        fill_v = '{24'h010203, 24'h111213, 24'h212223, 24'h313233};
        rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;

        // Reset values
        step(); step();
        @(negedge clk);
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_afull", 64'(afull), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        chk("rst_wr_ready", 64'(wr_ready), 64'(1));
        step();
        rst = 1'b0;
        chk_en = 1'b1;

        // Fill to full, extra write dropped, then drain
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = fill_v[i]; step();
        end
        wr_data = 24'hFFFFFF; step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("t2_full", 64'(full), 64'(1));
        chk("t2_level", 64'(level), 64'(4));
        rd_ready = 1'b1;
        repeat (8) step();
        rd_ready = 1'b0;

        // Streaming
        wr_valid = 1'b1; rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = PW'(32'h100 + i); step();
        end
        wr_valid = 1'b0;
        repeat (6) step();
        rd_ready = 1'b0;

        // Backpressure: writes continue until full while the head is held
        wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = PW'(32'h400 + i); step();
        end
        rd_ready = 1'b1;
        for (int i = 6; i < 12; i++) begin
            wr_data = PW'(32'h400 + i); step();
        end
        wr_valid = 1'b0;
        repeat (6) step();
        rd_ready = 1'b0;

        // Full with simultaneous pop: write refused, accepted the next cycle
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = PW'(32'h50 + i); step();
        end
        wr_valid = 1'b0;
        repeat (2) step();
        wr_valid = 1'b1; wr_data = 24'h00005A; rd_ready = 1'b1;
        step();
        @(negedge clk);
        chk("t5_level_after_pop", 64'(level), 64'(3));
        chk("t5_wr_ready", 64'(wr_ready), 64'(1));
        rd_ready = 1'b0;
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("t5_level_refill", 64'(level), 64'(4));
        rd_ready = 1'b1;
        repeat (7) step();
        rd_ready = 1'b0;

        // Flush mid-operation drops both same-cycle transfers
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = PW'(32'h60 + i); step();
        end
        wr_valid = 1'b0;
        repeat (3) step();
        clear = 1'b1; wr_valid = 1'b1; wr_data = 24'h777777; rd_ready = 1'b1;
        step();
        clear = 1'b0; wr_data = 24'hAABBCC;
        @(negedge clk);
        chk("t6_flush_level", 64'(level), 64'(0));
        chk("t6_flush_rd_valid", 64'(rd_valid), 64'(0));
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("t6_lat0_rd_valid", 64'(rd_valid), 64'(0));
        step();
        @(negedge clk);
        chk("t6_lat1_rd_valid", 64'(rd_valid), 64'(0));
        step();
        @(negedge clk);
        chk("t6_lat2_rd_valid", 64'(rd_valid), 64'(1));
        chk("t6_first_out", 64'(rd_data), 64'(24'hAABBCC));
        repeat (3) step();

        // Randomized traffic with varying consumer pressure and occasional flushes
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                wr_valid = ($urandom_range(0, 99) < 60);
                rd_ready = ($urandom_range(0, 99) < (30 + ph * 30));
                wr_data  = PW'($urandom);
                clear    = ($urandom_range(0, 199) == 0);
                step();
            end
        end

        clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b1;
        repeat (10) step();
        @(negedge clk);
        chk("final_drained", 64'(exp_data.size()), 64'(0));
        chk("final_level", 64'(level), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
